// File: rtl/pipe_hazard_ctl.sv
// Stall/flush controller for the five-stage pipeline: post-reset clearing, load-use bubbles,
// taken-branch flushes and data-memory waits with a timeout, plus saturating statistics.
module pipe_hazard_ctl #(
    parameter int INIT_CYCLES = 3,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             timeout_err
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic apply_rules;
    logic branch_fire;
    logic load_use;

    assign load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));

    // NOTE: every output and next-state is given a default before the case so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        apply_rules   = 1'b0;
        branch_fire   = 1'b0;

        case (state_q)
            ST_INIT: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
                    init_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    wait_cnt_d = WW'(1);
                    state_d    = ST_MEM_WAIT;
                end else begin
                    apply_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // The RUN cycle that entered this state already counted as stall cycle one.
                if (dmem_ready || (wait_cnt_q == WW'(MEM_TIMEOUT))) begin
                    apply_rules = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = ST_RUN;
                    if (!dmem_ready) timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (apply_rules) begin
            if (branch_taken) begin
                branch_fire  = 1'b1;
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != ST_INIT) && !pc_en && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch_fire && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values; the asynchronous reset clears all state, counters included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: inputs change on the falling edge, outputs are
// checked 1 ns later, and state advances on the rising edge in between.
module tb_pipe_hazard_ctl;

    localparam int CNT_W = 4;

    // Packed control order: {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem flushes}
    localparam logic [7:0] C_INIT   = 8'b00000_111;
    localparam logic [7:0] C_RUN    = 8'b11111_000;
    localparam logic [7:0] C_STALL  = 8'b00000_000;
    localparam logic [7:0] C_BRANCH = 8'b11111_111;
    localparam logic [7:0] C_LU     = 8'b00011_010;
    localparam logic [7:0] M_LU     = 8'b11011_111;  // id_ex_en is a don't-care under flush

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       id_rs = '0, id_rt = '0, id_ex_rt = '0;
    logic             id_ex_memread = 1'b0, branch_taken = 1'b0;
    logic             dmem_req = 1'b0, dmem_ready = 1'b0;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             timeout_err;
    logic [7:0]       ctl;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctl #(.INIT_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .timeout_err(timeout_err)
    );

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_ex_rt = '0; id_ex_memread = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Pulse reset, then walk the three INIT cycles and land in RUN.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        check("rst_ctl", 32'(ctl), 32'(C_INIT));
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        next_cycle();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("init%0d_ctl", i), 32'(ctl), 32'(C_INIT));
            next_cycle();
        end
        check("init_done_ctl", 32'(ctl), 32'(C_RUN));
        check("init_stall_cnt", 32'(stall_cnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("por_ctl", 32'(ctl), 32'(C_INIT));
        check("por_flush_cnt", 32'(flush_cnt), 32'd0);
        do_reset();

        // Load-use on rs: exactly one bubble, then normal flow.
        id_ex_memread = 1'b1; id_ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        check("lu_rs_ctl", 32'(ctl & M_LU), 32'(C_LU));
        next_cycle();
        clear_inputs(); #1;
        check("lu_rs_after_ctl", 32'(ctl), 32'(C_RUN));
        check("lu_rs_stall_cnt", 32'(stall_cnt), 32'd1);

        // Load-use on rt.
        id_ex_memread = 1'b1; id_ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3;
        #1;
        check("lu_rt_ctl", 32'(ctl & M_LU), 32'(C_LU));
        next_cycle();
        clear_inputs(); #1;
        check("lu_rt_stall_cnt", 32'(stall_cnt), 32'd2);

        // Register zero never creates a hazard; a load with no match neither.
        id_ex_memread = 1'b1; id_ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        check("lu_r0_ctl", 32'(ctl), 32'(C_RUN));
        next_cycle();
        id_ex_memread = 1'b1; id_ex_rt = 5'd9; id_rs = 5'd4; id_rt = 5'd7;
        #1;
        check("lu_nomatch_ctl", 32'(ctl), 32'(C_RUN));
        next_cycle();
        clear_inputs(); #1;
        check("lu_r0_stall_cnt", 32'(stall_cnt), 32'd2);

        // Branch beats a simultaneous load-use.
        do_reset();
        branch_taken = 1'b1; id_ex_memread = 1'b1; id_ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        check("br_lu_ctl", 32'(ctl), 32'(C_BRANCH));
        next_cycle();
        clear_inputs(); #1;
        check("br_after_ctl", 32'(ctl), 32'(C_RUN));
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Memory stall for four cycles, ready on the fifth.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mw%0d_ctl", i), 32'(ctl), 32'(C_STALL));
            next_cycle();
        end
        dmem_ready = 1'b1; #1;
        check("mw_release_ctl", 32'(ctl), 32'(C_RUN));
        next_cycle();
        clear_inputs(); #1;
        check("mw_stall_cnt", 32'(stall_cnt), 32'd4);
        check("mw_timeout_err", 32'(timeout_err), 32'd0);

        // Branch arriving with a memory stall: stall first, flush in the release cycle.
        dmem_req = 1'b1; branch_taken = 1'b1; #1;
        check("br_mw_stall_ctl", 32'(ctl), 32'(C_STALL));
        next_cycle();
        dmem_ready = 1'b1; #1;
        check("br_mw_release_ctl", 32'(ctl), 32'(C_BRANCH));
        next_cycle();
        clear_inputs(); #1;
        check("br_mw_flush_cnt", 32'(flush_cnt), 32'd2);
        check("br_mw_stall_cnt", 32'(stall_cnt), 32'd5);

        // Timeout: eight stalled cycles, forced release, sticky error.
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0; #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to%0d_ctl", i), 32'(ctl), 32'(C_STALL));
            next_cycle();
        end
        check("to_release_ctl", 32'(ctl), 32'(C_RUN));
        check("to_err_before_edge", 32'(timeout_err), 32'd0);
        next_cycle();
        clear_inputs(); #1;
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_stall_cnt", 32'(stall_cnt), 32'd8);
        next_cycle();
        check("to_err_sticky", 32'(timeout_err), 32'd1);

        // Reset asserted mid-wait takes effect without a clock edge.
        dmem_req = 1'b1; #1;
        next_cycle();
        check("to_rewait_ctl", 32'(ctl), 32'(C_STALL));
        #1;
        rst = 1'b0;
        #1;
        check("midwait_rst_ctl", 32'(ctl), 32'(C_INIT));
        check("midwait_rst_err", 32'(timeout_err), 32'd0);
        check("midwait_rst_stall", 32'(stall_cnt), 32'd0);
        do_reset();

        // Twenty branch flushes saturate the 4-bit counter at 15.
        branch_taken = 1'b1; #1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("sat%0d_ctl", i), 32'(ctl), 32'(C_BRANCH));
            next_cycle();
        end
        clear_inputs(); #1;
        check("sat_flush_cnt", 32'(flush_cnt), 32'd15);
        check("sat_stall_cnt", 32'(stall_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Central stall/flush controller for the five-stage MIPS pipeline. It watches the IF/ID, ID/EX and EX/MEM pipeline registers and the data-memory handshake, and drives a per-stage enable and flush that every pipeline register honours. It sequences four things: post-reset pipeline clearing, load-use bubbles, taken-branch flushes (the branch resolves in MEM via PCSrc), and multi-cycle data-memory waits with a timeout. It also keeps saturating stall and flush statistics.

## Interface
Parameters:
- INIT_CYCLES, 3: number of flush cycles after reset release.
- MEM_TIMEOUT, 255: maximum number of consecutive data-memory stall cycles before a forced release.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  5  instr[25:21] from IF/ID.
- id_rt  in  5  instr[20:16] from IF/ID.
- id_ex_memread  in  1  ID/EX MemRead control bit.
- id_ex_rt  in  5  ID/EX rt field.
- branch_taken  in  1  PCSrc from MEM (Branch & Zero).
- dmem_req  in  1  EX/MEM MemRead | MemWrite.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  per-stage load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all controls 0) at the next edge. A flush overrides the matching enable.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- flush_cnt  out  CNT_W  saturating count of branch flushes.
- timeout_err  out  1  sticky; set on a memory timeout.

## Operation
States are INIT, RUN and MEM_WAIT. Outputs are combinational from the state and the inputs. Counters and state are registered.

INIT (the reset state):
- pc_en=0 and mem_wb_en=0.
- All three flushes are 1.
- The other enables are 0.
- init_cnt increments each cycle. After INIT_CYCLES cycles, go to RUN.

RUN: conditions are evaluated in priority order.
1. Memory stall, when dmem_req=1 and dmem_ready=0:
   - All enables are 0 and all flushes are 0.
   - wait_cnt is set to 1; go to MEM_WAIT.
2. Branch taken, when branch_taken=1:
   - All enables are 1.
   - if_id_flush, id_ex_flush and ex_mem_flush are 1.
   - flush_cnt increments. Any load-use condition is ignored.
3. Load-use, when id_ex_memread=1, id_ex_rt≠0, and id_ex_rt equals id_rs or id_rt:
   - pc_en=0 and if_id_en=0.
   - id_ex_flush=1.
   - ex_mem_en=1 and mem_wb_en=1.
4. Otherwise all enables are 1 and all flushes are 0.

MEM_WAIT:
- Release when dmem_ready=1 or wait_cnt==MEM_TIMEOUT. In the release cycle, rules 2–4 of RUN apply, wait_cnt is cleared, and the state returns to RUN.
- A release without ready sets timeout_err.
- Otherwise all enables and flushes are 0 and wait_cnt increments.
- The maximum number of stalled cycles is MEM_TIMEOUT.

Statistics:
- stall_cnt increments on every cycle where pc_en=0 outside INIT.
- Both counters saturate at all-ones and never wrap.
- timeout_err is cleared only by reset.

## Timing
- rst=0 forces immediately, without waiting for a clock edge: state=INIT, init_cnt=0, wait_cnt=0, stall_cnt=0, flush_cnt=0, timeout_err=0. The outputs therefore show INIT values: pc_en=0 and all flushes=1.
- Reset asserted mid-stall or mid-flush abandons the operation. After release, INIT runs in full.
- Decision latency is zero. Controls are valid in the same cycle as their causing inputs and take effect at the next rising edge.
- A load-use produces exactly one bubble. On the following cycle the load is in EX/MEM and the hazard disappears naturally.
- A branch and a memory stall in the same cycle: the stall wins. EX/MEM is frozen, so branch_taken stays stable and the flush happens in the release cycle.
- A memory stall during a load-use: the whole pipeline freezes and no bubble is inserted until release.

## Test plan
- Reset release with INIT_CYCLES=3: flushes=1 and pc_en=0 for exactly 3 cycles, then RUN with all enables 1, and stall_cnt stays 0.
- Load-use with id_ex_memread=1, id_ex_rt=8, id_rs=8: one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, then normal flow; stall_cnt=1. Repeat with id_ex_rt=0: no stall.
- branch_taken=1 for one cycle, asserted together with a load-use hazard: only the three flushes occur, with pc_en=1; flush_cnt=1 and stall_cnt=0.
- dmem_req=1 with dmem_ready low for 4 cycles, then high: enables are 0 for 4 cycles, release in the 5th cycle; stall_cnt=4 and timeout_err=0.
- MEM_TIMEOUT=8 with dmem_ready held at 0: exactly 8 stalled cycles, forced release, timeout_err=1 and sticky. Then assert rst low mid-wait: timeout_err=0 and the block is in INIT immediately.
- With CNT_W=4, run 20 branch flushes: flush_cnt saturates at 15.
